// File: rtl/cv32e40p_obi_sram_bridge.sv
// rtl/cv32e40p_obi_sram_bridge.sv - OBI slave bridging granted transactions onto a 1-cycle single-port SRAM
// In-order responses via a bypass from the pending stage or a small response FIFO when rready stalls.
module cv32e40p_obi_sram_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_WORDS  = 16384,
    parameter int          RESP_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic                         we_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  wdata_i,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [31:0]                  rdata_o,
    output logic                         err_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [3:0]                   sram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [31:0]                  sram_wdata_o,
    input  logic [31:0]                  sram_rdata_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic          pend_valid;
    logic          pend_we;
    logic          pend_err;
    logic [31:0]   pend_rdata;

    logic [31:0]   fifo_data [RESP_DEPTH];
    logic          fifo_err  [RESP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_nonempty;

    logic [CW:0]   occ;
    logic          in_range;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // 33-bit compare so a window touching the top of the address space cannot wrap
    assign in_range = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, addr_i} < ({1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2)));

    assign occ           = (CW+1)'(pend_valid) + (CW+1)'(fifo_count);
    assign fifo_nonempty = (fifo_count != '0);

    // Credit check ignores a same-cycle pop to keep gnt off the rready path
    assign gnt_o = req_i & ~stall_i & ~rst_i & (occ < (CW+1)'(RESP_DEPTH));

    assign sram_req_o   = gnt_o & in_range;
    assign sram_we_o    = sram_req_o & we_i;
    assign sram_be_o    = sram_req_o ? be_i : 4'h0;
    assign sram_wdata_o = sram_req_o ? wdata_i : 32'h0;
    assign sram_addr_o  = sram_req_o ? AW'((addr_i - BASE_ADDR) >> 2) : '0;

    assign pend_rdata = (pend_valid & ~pend_we & ~pend_err) ? sram_rdata_i : 32'h0;

    assign push = pend_valid & (fifo_nonempty | ~rready_i);
    assign pop  = fifo_nonempty & rready_i;

    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = 32'h0;
        err_o    = 1'b0;
        if (fifo_nonempty) begin
            rvalid_o = 1'b1;
            rdata_o  = fifo_data[rd_ptr];
            err_o    = fifo_err[rd_ptr];
        end else if (pend_valid) begin
            rvalid_o = 1'b1;
            rdata_o  = pend_rdata;
            err_o    = pend_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_err   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            pend_valid <= gnt_o;
            pend_we    <= gnt_o & we_i;
            pend_err   <= gnt_o & ~in_range;
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; validity is tracked by the count
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= pend_rdata;
            fifo_err[wr_ptr]  <= pend_err;
        end
    end

`ifdef CV32E40P_ASSERT_ON
    logic        hold_q;
    logic [31:0] rdata_q;
    logic        err_q;

    always_ff @(posedge clk_i) begin
        hold_q  <= ~rst_i & rvalid_o & ~rready_i;
        rdata_q <= rdata_o;
        err_q   <= err_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (occ <= (CW+1)'(RESP_DEPTH));
            assert (!(push && fifo_count == CW'(RESP_DEPTH)));
            if (hold_q) begin
                assert (rvalid_o && rdata_o == rdata_q && err_o == err_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
// tb/tb_cv32e40p_obi_sram_bridge.sv - directed and randomized checks of the OBI to SRAM bridge
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_cv32e40p_obi_sram_bridge;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          MW   = 256;
    localparam int          RD   = 2;
    localparam int          NTX  = 1000;

    logic        clk = 1'b0;
    logic        rst, stall, req, gnt, we, rvalid, rready, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        sram_req, sram_we;
    logic [3:0]  sram_be;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    always #5 clk = ~clk;

    cv32e40p_obi_sram_bridge #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (MW),
        .RESP_DEPTH(RD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .req_i       (req),
        .gnt_o       (gnt),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .rdata_o     (rdata),
        .err_o       (err),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_be_o   (sram_be),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_rdata_i(sram_rdata)
    );

    // SRAM model: byte-masked writes, read data one cycle after the strobe
    logic [31:0] mem [MW];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MW; i++) mem[i] <= 32'h0;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
    endtask

    // Reference state for the randomized phase (words 0..7, untouched by directed steps)
    logic [31:0] ref_mem [8];
    logic [32:0] exp_q [$];
    logic        have, t_we, t_oor;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wd;
    int          t_idx;
    int          issued, received, outstanding, max_out;
    logic        prev_hold;
    logic [33:0] prev_vec;

    task automatic observe;
        logic [32:0] e;
        if (prev_hold) check("hold", {rvalid, err, rdata}, prev_vec);
        if (gnt) begin
            if (t_oor) begin
                exp_q.push_back({1'b1, 32'h0});
            end else if (t_we) begin
                exp_q.push_back({1'b0, 32'h0});
                for (int b = 0; b < 4; b++)
                    if (t_be[b]) ref_mem[t_idx][8*b +: 8] = t_wd[8*b +: 8];
            end else begin
                exp_q.push_back({1'b0, ref_mem[t_idx]});
            end
            issued++;
            outstanding++;
            have = 1'b0;
        end
        if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check("resp_spurious", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("resp_order", {err, rdata}, e);
            end
            received++;
            outstanding--;
        end
        if (outstanding > max_out) max_out = outstanding;
        prev_hold = rvalid & ~rready;
        prev_vec  = {rvalid, err, rdata};
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
        mem_clr = 1'b1; rst = 1'b1; stall = 1'b0; rready = 1'b1;
        drive(1'b1, 1'b0, 4'hF, BASE, 32'h0);
        tick; tick;
        settle;
        check("rst_gnt", gnt, 0);
        check("rst_sram_req", sram_req, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        tick;
        mem_clr = 1'b0; rst = 1'b0;

        // Back-to-back write then read
        drive(1'b1, 1'b1, 4'hF, BASE + 32'h100, 32'hDEAD_BEEF);
        settle;
        check("b2b_w_gnt", gnt, 1);
        check("b2b_w_sreq", sram_req, 1);
        check("b2b_w_saddr", sram_addr, 8'h40);
        check("b2b_w_swe", sram_we, 1);
        check("b2b_w_rvalid", rvalid, 0);
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h100, 32'h0);
        settle;
        check("b2b_r_gnt", gnt, 1);
        check("b2b_wresp", {rvalid, err, rdata}, {2'b10, 32'h0});
        tick;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle;
        check("b2b_rresp", {rvalid, err, rdata}, {2'b10, 32'hDEAD_BEEF});
        tick;

        // Byte enables
        drive(1'b1, 1'b1, 4'hF, BASE + 32'h104, 32'h0);
        tick;
        drive(1'b1, 1'b1, 4'b0101, BASE + 32'h104, 32'h1122_3344);
        settle;
        check("be_sbe", sram_be, 4'b0101);
        check("be_swdata", sram_wdata, 32'h1122_3344);
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h104, 32'h0);
        tick;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle;
        check("be_rresp", {rvalid, err, rdata}, {2'b10, 32'h0022_0044});
        tick;

        // Range boundaries
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h3FC, 32'h0);
        settle;
        check("last_sreq", sram_req, 1);
        check("last_saddr", sram_addr, 8'hFF);
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h400, 32'h0);
        settle;
        check("oor_hi_gnt", gnt, 1);
        check("oor_hi_sreq", sram_req, 0);
        check("oor_hi_saddr", sram_addr, 0);
        check("last_resp", {rvalid, err, rdata}, {2'b10, 32'h0});
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE - 32'h4, 32'h0);
        settle;
        check("oor_lo_gnt", gnt, 1);
        check("oor_lo_sreq", sram_req, 0);
        check("oor_hi_resp", {rvalid, err, rdata}, {2'b11, 32'h0});
        tick;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle;
        check("oor_lo_resp", {rvalid, err, rdata}, {2'b11, 32'h0});
        tick;
        settle;
        check("oor_idle", rvalid, 0);
        tick;

        // Back-pressure: words 1..4, rready low, two credits
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 4'hF, BASE + 32'h200 + 32'(4*k), 32'(k + 1));
            tick;
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick;
        rready = 1'b0;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h200, 32'h0);
        settle;
        check("bp_gnt1", gnt, 1);
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h204, 32'h0);
        settle;
        check("bp_gnt2", gnt, 1);
        check("bp_resp_c2", {rvalid, err, rdata}, {2'b10, 32'd1});
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h208, 32'h0);
        settle;
        check("bp_nognt_c3", gnt, 0);
        check("bp_hold_c3", {rvalid, err, rdata}, {2'b10, 32'd1});
        tick;
        settle;
        check("bp_nognt_c4", gnt, 0);
        check("bp_hold_c4", {rvalid, err, rdata}, {2'b10, 32'd1});
        tick;
        rready = 1'b1;
        settle;
        check("bp_nognt_c5", gnt, 0);
        check("bp_resp1", {rvalid, err, rdata}, {2'b10, 32'd1});
        tick;
        settle;
        check("bp_gnt3", gnt, 1);
        check("bp_resp2", {rvalid, err, rdata}, {2'b10, 32'd2});
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h20C, 32'h0);
        settle;
        check("bp_gnt4", gnt, 1);
        check("bp_resp3", {rvalid, err, rdata}, {2'b10, 32'd3});
        tick;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle;
        check("bp_resp4", {rvalid, err, rdata}, {2'b10, 32'd4});
        tick;
        settle;
        check("bp_idle", rvalid, 0);
        tick;

        // Reset with two responses outstanding
        rready = 1'b0;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h200, 32'h0);
        tick;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h204, 32'h0);
        tick;
        rst = 1'b1;
        settle;
        check("mrst_gnt", gnt, 0);
        check("mrst_sreq", sram_req, 0);
        tick;
        rst = 1'b0; rready = 1'b1;
        drive(1'b1, 1'b0, 4'hF, BASE + 32'h208, 32'h0);
        settle;
        check("mrst_rvalid", rvalid, 0);
        check("mrst_gnt_after", gnt, 1);
        tick;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle;
        check("mrst_resp", {rvalid, err, rdata}, {2'b10, 32'd3});
        tick;
        settle;
        check("mrst_idle", rvalid, 0);
        tick;

        // Randomized stall and rready against the reference queue
        have = 1'b0; issued = 0; received = 0; outstanding = 0; max_out = 0;
        prev_hold = 1'b0; prev_vec = '0;
        t_we = 1'b0; t_oor = 1'b0; t_be = 4'h0; t_addr = 32'h0; t_wd = 32'h0; t_idx = 0;
        for (int c = 0; c < 20000 && issued < NTX; c++) begin
            if (!have) begin
                t_idx = int'($urandom_range(0, 7));
                t_oor = ($urandom_range(0, 7) == 0);
                if (t_oor)
                    t_addr = ($urandom_range(0, 1) == 1) ? BASE + 32'h400 + 32'(4*t_idx)
                                                         : BASE - 32'h4 - 32'(4*t_idx);
                else
                    t_addr = BASE + 32'(4*t_idx) + 32'($urandom_range(0, 3));
                t_we = 1'($urandom_range(0, 1));
                t_be = 4'($urandom_range(0, 15));
                t_wd = $urandom;
                have = 1'b1;
            end
            drive(1'b1, t_we, t_be, t_addr, t_wd);
            stall  = 1'($urandom_range(0, 1));
            rready = ($urandom_range(0, 3) != 0);
            settle;
            observe();
            tick;
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        stall = 1'b0; rready = 1'b1;
        for (int c = 0; c < 50 && received < issued; c++) begin
            settle;
            observe();
            tick;
        end
        check("rand_issued", 64'(issued), 64'(NTX));
        check("rand_received", 64'(received), 64'(NTX));
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rand_max_occ", 64'(max_out <= RD), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
